// File: rtl/line_cmd_scheduler.sv
// Line command scheduler: queues line-drawing commands in a small FIFO and
// sequences them one at a time through an external line drawer, forwarding
// each drawn pixel to the framebuffer write port.
module line_cmd_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    // command handshake
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y1,
    input  logic        cmd_color,

    // line drawer control
    output logic        ld_reset,
    output logic [10:0] ld_x0,
    output logic [10:0] ld_y0,
    output logic [10:0] ld_x1,
    output logic [10:0] ld_y1,
    input  logic [10:0] ld_x,
    input  logic [10:0] ld_y,
    input  logic        ld_finished,

    // framebuffer write port
    output logic        pixel_write,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        pixel_color,

    // status
    output logic        busy,
    output logic [15:0] lines_done
);

    localparam int unsigned COORD_W = 11;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DONE_W  = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic               color;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    cmd_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    cmd_t               cur;
    cmd_t               push_entry;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               line_complete;

    // FIFO status is derived from the occupancy counter only, never from cmd_valid
    assign fifo_empty    = (count == CNT_W'(0));
    assign cmd_ready     = (count != CNT_W'(DEPTH));
    assign push          = cmd_valid && cmd_ready;
    assign pop           = (state == IDLE) && !fifo_empty;
    assign line_complete = (state == DRAW) && ld_finished;

    // pack the incoming command for storage
    assign push_entry = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};

    // FIFO storage; entries carry no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // current line: latched on the pop, held stable until the next pop
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= '0;
        end else if (pop) begin
            cur <= mem[rd_ptr];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; ld_finished only matters while drawing
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = DRAW;
            end
            DRAW: begin
                if (ld_finished) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: drawer held in reset until DRAW, pixels written only while drawing
    always_comb begin
        ld_reset    = 1'b1;
        pixel_write = 1'b0;
        case (state)
            DRAW: begin
                ld_reset    = 1'b0;
                pixel_write = !ld_finished;
            end
            default: begin
                ld_reset    = 1'b1;
                pixel_write = 1'b0;
            end
        endcase
    end

    // completed-line counter, wraps modulo 2^16
    always_ff @(posedge clk) begin
        if (reset) begin
            lines_done <= '0;
        end else if (line_complete) begin
            lines_done <= lines_done + DONE_W'(1);
        end
    end

    assign ld_x0       = cur.x0;
    assign ld_y0       = cur.y0;
    assign ld_x1       = cur.x1;
    assign ld_y1       = cur.y1;
    assign pixel_x     = ld_x;
    assign pixel_y     = ld_y;
    assign pixel_color = cur.color;
    assign busy        = (state != IDLE) || !fifo_empty;

endmodule
